// File: rtl/demux3_stream_if.sv
// Stream bundle for the 1-to-3 demultiplexer: one producer side and
// three consumer channels, plus the illegal-select counter.
//   D/S/VALID_IN/READY_IN : producer handshake (word and destination)
//   YA..YC/VA..VC/RA..RC  : consumer channels A, B, C
//   ERR_CNT               : saturating count of accepted words with S=11
interface demux3_stream_if #(
    parameter int WIDTH = 1,
    parameter int ERRW  = 8
);
    logic [WIDTH-1:0] D;
    logic [1:0]       S;
    logic             VALID_IN;
    logic             READY_IN;

    logic [WIDTH-1:0] YA;
    logic [WIDTH-1:0] YB;
    logic [WIDTH-1:0] YC;
    logic             VA;
    logic             VB;
    logic             VC;
    logic             RA;
    logic             RB;
    logic             RC;

    logic [ERRW-1:0]  ERR_CNT;

    // Environment side: producer plus the three consumers.
    modport master (
        output D,
        output S,
        output VALID_IN,
        input  READY_IN,
        input  YA,
        input  YB,
        input  YC,
        input  VA,
        input  VB,
        input  VC,
        output RA,
        output RB,
        output RC,
        input  ERR_CNT
    );

    // Demultiplexer side.
    modport slave (
        input  D,
        input  S,
        input  VALID_IN,
        output READY_IN,
        output YA,
        output YB,
        output YC,
        output VA,
        output VB,
        output VC,
        input  RA,
        input  RB,
        input  RC,
        output ERR_CNT
    );
endinterface

// File: rtl/demux3_stream.sv
// Registered 1-to-3 stream demultiplexer with a single-entry buffer.
// Ports: clk, reset_n (async, active-low), bus (demux3_stream_if.slave).
module demux3_stream #(
    parameter int WIDTH = 1,
    parameter int ERRW  = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    demux3_stream_if.slave  bus
);

    localparam logic [1:0] DEST_A   = 2'b00;
    localparam logic [1:0] DEST_B   = 2'b01;
    localparam logic [1:0] DEST_C   = 2'b10;
    localparam logic [1:0] DEST_BAD = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [1:0]       dest_q;
    logic [1:0]       dest_d;
    logic [ERRW-1:0]  err_q;
    logic [ERRW-1:0]  err_d;

    logic full;
    logic sel_a;
    logic sel_b;
    logic sel_c;
    logic dest_ready;
    logic drain;
    logic ready;
    logic acc;
    logic legal;
    logic illegal;
    logic err_max;

    // Destination decode of the buffered word.
    assign full  = (state_q == HOLD);
    assign sel_a = (dest_q == DEST_A);
    assign sel_b = (dest_q == DEST_B);
    assign sel_c = (dest_q == DEST_C);

    // Only the addressed consumer can release the buffer; the others'
    // ready inputs never reach the handshake.
    always_comb begin
        dest_ready = 1'b0;
        unique case (1'b1)
            sel_a:   dest_ready = bus.RA;
            sel_b:   dest_ready = bus.RB;
            sel_c:   dest_ready = bus.RC;
            default: dest_ready = 1'b0;
        endcase
    end

    // READY_IN depends on the consumer readies and buffer state only,
    // never on VALID_IN, so it can be chained without loops.
    assign drain   = full & dest_ready;
    assign ready   = ~full | drain;
    assign acc     = bus.VALID_IN & ready;
    assign legal   = acc & (bus.S != DEST_BAD);
    assign illegal = acc & (bus.S == DEST_BAD);
    assign err_max = &err_q;

    // Next state, buffer load and error counting.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dest_d  = dest_q;
        err_d   = err_q;

        unique case (state_q)
            EMPTY: begin
                if (legal) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Drain with a legal accept refills in place.
                if (drain && !legal) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (legal) begin
            data_d = bus.D;
            dest_d = bus.S;
        end

        // Illegal words are swallowed; the counter sticks at all-ones.
        if (illegal && !err_max) begin
            err_d = err_q + ERRW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            dest_q  <= DEST_A;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            err_q   <= err_d;
        end
    end

    // Non-addressed channels are held at zero.
    assign bus.READY_IN = ready;

    assign bus.VA = full & sel_a;
    assign bus.VB = full & sel_b;
    assign bus.VC = full & sel_c;

    assign bus.YA = sel_a ? data_q : '0;
    assign bus.YB = sel_b ? data_q : '0;
    assign bus.YC = sel_c ? data_q : '0;

    assign bus.ERR_CNT = err_q;

endmodule

// File: tb/tb_demux3_stream.sv
// Testbench for demux3_stream: directed scenarios plus a scoreboard
// that follows every accepted word to the channel that delivers it.
module tb_demux3_stream;

    logic clk;
    logic reset_n;

    int checks;
    int passes;
    int err_exp;

    logic [9:0] exp_q[$];

    demux3_stream_if #(.WIDTH(8), .ERRW(8)) bus ();
    demux3_stream_if #(.WIDTH(8), .ERRW(2)) bus2 ();

    demux3_stream #(.WIDTH(8), .ERRW(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    demux3_stream #(.WIDTH(8), .ERRW(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: inputs change only just after posedge, so the values
    // seen at negedge are the ones the next posedge acts on.
    always @(negedge clk) begin
        if (reset_n) begin
            logic [1:0] ch;
            logic [9:0] exp;
            logic       xfer;
            xfer = 1'b0;
            ch   = 2'b00;
            if (bus.VA && bus.RA) begin
                xfer = 1'b1;
                ch   = 2'b00;
            end else if (bus.VB && bus.RB) begin
                xfer = 1'b1;
                ch   = 2'b01;
            end else if (bus.VC && bus.RC) begin
                xfer = 1'b1;
                ch   = 2'b10;
            end
            checks++;
            if ($countones({bus.VA, bus.VB, bus.VC}) > 1)
                $display("FAIL onehot_valid: got %b required at most one",
                         {bus.VA, bus.VB, bus.VC});
            else
                passes++;
            if (xfer) begin
                logic [7:0] y;
                y = (ch == 2'b00) ? bus.YA :
                    (ch == 2'b01) ? bus.YB : bus.YC;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected: got ch%0d %h required none",
                             ch, y);
                end else begin
                    exp = exp_q.pop_front();
                    if ({ch, y} !== exp)
                        $display("FAIL sb_word: got ch%0d %h required ch%0d %h",
                                 ch, y, exp[9:8], exp[7:0]);
                    else
                        passes++;
                end
            end
            if (bus.VALID_IN && bus.READY_IN) begin
                if (bus.S != 2'b11)
                    exp_q.push_back({bus.S, bus.D});
                else if (err_exp < 255)
                    err_exp++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until the block takes it.
    task automatic send(input logic [7:0] d, input logic [1:0] s);
        bit ok;
        ok = 1'b0;
        bus.D        = d;
        bus.S        = s;
        bus.VALID_IN = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.READY_IN) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok)
            $display("FAIL send_timeout: got READY_IN=0 required 1");
        else
            passes++;
        step();
        bus.VALID_IN = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if ({bus.VA, bus.VB, bus.VC} !== 3'b000 ||
            {bus.YA, bus.YB, bus.YC} !== 24'h0 ||
            bus.ERR_CNT !== 8'h0)
            $display("FAIL reset_outputs: got V=%b Y=%h E=%h required 0",
                     {bus.VA, bus.VB, bus.VC},
                     {bus.YA, bus.YB, bus.YC}, bus.ERR_CNT);
        else
            passes++;
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.READY_IN !== 1'b1)
            $display("FAIL reset_ready: got %b required 1", bus.READY_IN);
        else
            passes++;
        step();
    endtask

    task automatic test_routing();
        bus.RA = 1'b1;
        bus.RB = 1'b1;
        bus.RC = 1'b1;
        send(8'hA5, 2'b00);
        checks++;
        if ({bus.VA, bus.VB, bus.VC} !== 3'b100 || bus.YA !== 8'hA5)
            $display("FAIL route_a: got V=%b YA=%h required 100 a5",
                     {bus.VA, bus.VB, bus.VC}, bus.YA);
        else
            passes++;
        send(8'h3C, 2'b01);
        checks++;
        if ({bus.VA, bus.VB, bus.VC} !== 3'b010 || bus.YB !== 8'h3C)
            $display("FAIL route_b: got V=%b YB=%h required 010 3c",
                     {bus.VA, bus.VB, bus.VC}, bus.YB);
        else
            passes++;
        send(8'hF0, 2'b10);
        checks++;
        if ({bus.VA, bus.VB, bus.VC} !== 3'b001 || bus.YC !== 8'hF0)
            $display("FAIL route_c: got V=%b YC=%h required 001 f0",
                     {bus.VA, bus.VB, bus.VC}, bus.YC);
        else
            passes++;
        step();
    endtask

    task automatic test_backpressure();
        bus.RB = 1'b0;
        send(8'h11, 2'b01);
        bus.D        = 8'h22;
        bus.S        = 2'b00;
        bus.VALID_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.READY_IN !== 1'b0 || bus.VB !== 1'b1 ||
                bus.YB !== 8'h11 || bus.VA !== 1'b0)
                $display("FAIL bp_stall: got R=%b VB=%b YB=%h VA=%b required 0 1 11 0",
                         bus.READY_IN, bus.VB, bus.YB, bus.VA);
            else
                passes++;
        end
        bus.RB = 1'b1;
        step();
        bus.VALID_IN = 1'b0;
        checks++;
        if (bus.VA !== 1'b1 || bus.YA !== 8'h22 || bus.VB !== 1'b0)
            $display("FAIL bp_release: got VA=%b YA=%h VB=%b required 1 22 0",
                     bus.VA, bus.YA, bus.VB);
        else
            passes++;
        step();
    endtask

    task automatic test_back_to_back();
        bus.RA       = 1'b1;
        bus.S        = 2'b00;
        bus.VALID_IN = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.D = 8'(i);
            @(negedge clk);
            checks++;
            if (bus.READY_IN !== 1'b1)
                $display("FAIL stream_ready: got %b required 1", bus.READY_IN);
            else
                passes++;
            step();
            checks++;
            if (bus.VA !== 1'b1 || bus.YA !== 8'(i))
                $display("FAIL stream_word: got VA=%b YA=%h required 1 %h",
                         bus.VA, bus.YA, 8'(i));
            else
                passes++;
        end
        bus.VALID_IN = 1'b0;
        step();
    endtask

    task automatic test_illegal();
        bus.D        = 8'hFF;
        bus.S        = 2'b11;
        bus.VALID_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.READY_IN !== 1'b1)
                $display("FAIL illegal_ready: got %b required 1", bus.READY_IN);
            else
                passes++;
            step();
            checks++;
            if ({bus.VA, bus.VB, bus.VC} !== 3'b000)
                $display("FAIL illegal_valid: got %b required 000",
                         {bus.VA, bus.VB, bus.VC});
            else
                passes++;
        end
        bus.VALID_IN = 1'b0;
        checks++;
        if (bus.ERR_CNT !== 8'd3 || int'(bus.ERR_CNT) != err_exp)
            $display("FAIL illegal_count: got %0d required 3 (model %0d)",
                     bus.ERR_CNT, err_exp);
        else
            passes++;
    endtask

    task automatic test_saturate();
        int e;
        bus2.D        = 8'h01;
        bus2.S        = 2'b11;
        bus2.VALID_IN = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            e = (i > 3) ? 3 : i;
            checks++;
            if (int'(bus2.ERR_CNT) != e)
                $display("FAIL sat_count: got %0d required %0d",
                         bus2.ERR_CNT, e);
            else
                passes++;
        end
        bus2.VALID_IN = 1'b0;
    endtask

    task automatic test_wrong_ready();
        bus.RA = 1'b0;
        bus.RB = 1'b1;
        bus.RC = 1'b1;
        send(8'h77, 2'b00);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.VA !== 1'b1 || bus.YA !== 8'h77 ||
                bus.READY_IN !== 1'b0)
                $display("FAIL wrong_ready: got VA=%b YA=%h R=%b required 1 77 0",
                         bus.VA, bus.YA, bus.READY_IN);
            else
                passes++;
            step();
        end
        bus.RA = 1'b1;
        step();
    endtask

    task automatic test_async_reset();
        bus.RC = 1'b0;
        send(8'h5A, 2'b10);
        checks++;
        if (bus.VC !== 1'b1 || bus.YC !== 8'h5A)
            $display("FAIL hold_c: got VC=%b YC=%h required 1 5a",
                     bus.VC, bus.YC);
        else
            passes++;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.VC !== 1'b0 || bus.YC !== 8'h0 || bus.ERR_CNT !== 8'h0)
            $display("FAIL async_reset: got VC=%b YC=%h E=%h required 0 0 0",
                     bus.VC, bus.YC, bus.ERR_CNT);
        else
            passes++;
        exp_q.delete();
        err_exp = 0;
        #3;
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.READY_IN !== 1'b1 || bus.VC !== 1'b0)
            $display("FAIL post_reset: got R=%b VC=%b required 1 0",
                     bus.READY_IN, bus.VC);
        else
            passes++;
        bus.RC = 1'b1;
        step();
    endtask

    initial begin
        checks  = 0;
        passes  = 0;
        err_exp = 0;
        bus.D        = '0;
        bus.S        = '0;
        bus.VALID_IN = 1'b0;
        bus.RA       = 1'b0;
        bus.RB       = 1'b0;
        bus.RC       = 1'b0;
        bus2.D        = '0;
        bus2.S        = '0;
        bus2.VALID_IN = 1'b0;
        bus2.RA       = 1'b1;
        bus2.RB       = 1'b1;
        bus2.RC       = 1'b1;

        test_reset();
        test_routing();
        test_backpressure();
        test_back_to_back();
        test_illegal();
        test_saturate();
        test_wrong_ready();
        test_async_reset();

        step();
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL sb_leftover: got %0d words required 0",
                     exp_q.size());
        else
            passes++;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
